// File: rtl/dec_serial.sv
// dec_serial: bit-serial decrementer (result = operando - 1 mod 2^WIDTH).
// The operand is walked LSB first with a ripple borrow, one bit per clock.
// A subtraction always takes exactly WIDTH shift cycles.
//
// Ports
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   start     request, only looked at while idle
//   operando  operand, captured on the edge that accepts start
//   dec       result, held until the next completion
//   borrow    final borrow (operand was zero, result wrapped to all ones)
//   zero      dec == 0
//   busy      shift in progress
//   done      one-cycle completion strobe
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; result outputs hold the last completion
// S_SHIFT | one operand bit per clock, WIDTH cycles, busy=1
// S_DONE  | result just published, done=1 for this single cycle

module dec_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] operando,
    output logic [WIDTH-1:0] dec,
    output logic             borrow,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] opnd_sr;
    logic [WIDTH-1:0] res_sr;
    logic             b;
    logic [CW-1:0]    cnt;

    logic             a;
    logic             r;
    logic             b_nxt;
    logic [WIDTH-1:0] res_nxt;

    // Next shift step; also what gets published on the final shift edge.
    always_comb begin
        a       = opnd_sr[0];
        r       = a ^ b;
        b_nxt   = ~a & b;
        res_nxt = {r, res_sr[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            opnd_sr <= '0;
            res_sr  <= '0;
            b       <= 1'b0;
            cnt     <= '0;
            dec     <= '0;
            borrow  <= 1'b0;
            zero    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        opnd_sr <= operando;
                        res_sr  <= '0;
                        b       <= 1'b1;   // borrow-in of 1 subtracts one
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    res_sr  <= res_nxt;
                    opnd_sr <= opnd_sr >> 1;
                    b       <= b_nxt;
                    cnt     <= cnt + CW'(1);
                    // No early exit when the borrow dies: latency stays fixed.
                    if (cnt == LAST) begin
                        dec    <= res_nxt;
                        borrow <= b_nxt;
                        zero   <= (res_nxt == '0);
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
